// File: rtl/isogeny_arith_pkg.sv
// ----------------------------------------------------------------------------
// isogeny_arith_pkg
//   Shared constants and types for the isogeny arithmetic datapath.
//   W_ACC     : width of the carry-save accumulator words (86 bits)
//   CSR_CHUNK : bits resolved per cycle by the carry-save resolver
//   CSR_NSEG  : number of resolver segments, ceil(W_ACC / CSR_CHUNK)
//   cs_state_t: resolver control states
// ----------------------------------------------------------------------------
package isogeny_arith_pkg;

    localparam int unsigned W_ACC     = 86;
    localparam int unsigned CSR_CHUNK = 22;
    localparam int unsigned CSR_NSEG  = (W_ACC + CSR_CHUNK - 1) / CSR_CHUNK;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cs_state_t;

endpackage

// File: rtl/cpa_slice.sv
// ----------------------------------------------------------------------------
// cpa_slice
//   Combinational CHUNK-bit carry-propagate adder slice: {co_o, s_o} = a_i + b_i + ci_i.
//   Ports:
//     a_i  [CHUNK-1:0]  first addend
//     b_i  [CHUNK-1:0]  second addend
//     ci_i              carry in
//     s_o  [CHUNK-1:0]  sum bits
//     co_o              carry out (bit CHUNK of the full sum)
// ----------------------------------------------------------------------------
module cpa_slice #(
    parameter int unsigned CHUNK = 22
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             ci_i,
    output logic [CHUNK-1:0] s_o,
    output logic             co_o
);

    always_comb begin
        {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, ci_i};
    end

endmodule

// File: rtl/cs_resolve_86.sv
// ----------------------------------------------------------------------------
// cs_resolve_86
//   Resolves one redundant (carry, sum) pair from the carry-save array into a
//   plain binary word. A single CHUNK-bit adder slice is reused over NSEG
//   cycles with the ripple carry held in a flop, keeping the full-width carry
//   chain off the multiplier's critical path.
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     in_valid   c_in/s_in valid
//     in_ready   a pair can be accepted this cycle
//     c_in [W]   carry vector
//     s_in [W]   sum vector
//     out_valid  sum/cout hold a completed result
//     out_ready  consumer takes the result this cycle
//     sum  [W]   (c_in + s_in) mod 2^W
//     cout       bit W of c_in + s_in
//     busy       high while resolving (RUN state)
// ----------------------------------------------------------------------------
module cs_resolve_86
    import isogeny_arith_pkg::*;
#(
    parameter int unsigned W     = W_ACC,
    parameter int unsigned CHUNK = CSR_CHUNK
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] c_in,
    input  logic [W-1:0] s_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int unsigned NSEG   = (W + CHUNK - 1) / CHUNK;
    localparam int unsigned SEG_W  = (NSEG > 1) ? $clog2(NSEG) : 1;
    // Width of the final (possibly short) segment.
    localparam int unsigned LAST_W = W - (NSEG - 1) * CHUNK;
    localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NSEG - 1);

    cs_state_t      state_q, state_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;

    logic [31:0]    shamt;
    logic [CHUNK-1:0] slice_a, slice_b, slice_s;
    logic           slice_co;
    logic           seg_co;
    logic [W-1:0]   seg_mask;
    logic [W-1:0]   seg_val;

    // Operand bits for the current segment. Shifting the W-bit operand right
    // zero-fills the top, so the short last segment is zero-extended for free.
    always_comb begin
        shamt   = CHUNK * 32'(seg_q);
        slice_a = CHUNK'(opa_q >> shamt);
        slice_b = CHUNK'(opb_q >> shamt);
    end

    cpa_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a_i  (slice_a),
        .b_i  (slice_b),
        .ci_i (carry_q),
        .s_o  (slice_s),
        .co_o (slice_co)
    );

    // The last segment is only LAST_W bits wide: its carry-out appears at bit
    // LAST_W of the slice result rather than at the slice's own carry-out.
    always_comb begin
        logic [CHUNK:0] slice_full;
        slice_full = {slice_co, slice_s};
        seg_co     = (seg_q == LAST_SEG) ? slice_full[LAST_W] : slice_co;
    end

    // Place the slice result at its segment position; bits shifted past W
    // (the unused top of the last segment) fall off.
    always_comb begin
        seg_mask = {{(W - CHUNK){1'b0}}, {CHUNK{1'b1}}} << shamt;
        seg_val  = {{(W - CHUNK){1'b0}}, slice_s} << shamt;
    end

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d   = c_in;
                    opb_d   = s_in;
                    seg_d   = '0;
                    carry_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = (sum_q & ~seg_mask) | (seg_val & seg_mask);
                carry_d = seg_co;
                if (seg_q == LAST_SEG) begin
                    cout_d  = seg_co;
                    seg_d   = '0;
                    state_d = DONE;
                end else begin
                    seg_d = seg_q + SEG_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        // Back-to-back: take the next pair as this result leaves.
                        opa_d   = c_in;
                        opb_d   = s_in;
                        seg_d   = '0;
                        carry_d = 1'b0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            seg_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_cs_resolve_86.sv
// ----------------------------------------------------------------------------
// tb_cs_resolve_86
//   Directed and randomised bench for cs_resolve_86. A negedge monitor keeps a
//   scoreboard of expected {cout, sum} values: pushed at each accept handshake,
//   popped and compared at each output handshake.
// ----------------------------------------------------------------------------
module tb_cs_resolve_86;

    localparam int W  = 86;
    localparam int WX = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] c_in;
    logic [W-1:0] s_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [W:0] exp_q[$];
    bit         rand_ready = 1'b0;

    logic         pv, pr;
    logic [W:0]   pres;

    always #5 clk = ~clk;

    cs_resolve_86 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c_in      (c_in),
        .s_in      (s_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pv <= 1'b0;
            pr <= 1'b0;
        end else begin
            if (pv && !pr) begin
                check("hold_valid", WX'(out_valid), WX'(1));
                check("hold_result", {cout, sum}, pres);
            end
            if (out_valid && out_ready) begin
                check("sb_pending", WX'(exp_q.size() != 0), WX'(1));
                if (exp_q.size() != 0) check("sb_result", {cout, sum}, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(ref_add(c_in, s_in));
            pv   <= out_valid;
            pr   <= out_ready;
            pres <= {cout, sum};
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a pair until accepted; afterwards scramble the inputs so any
    // late sampling would corrupt the result.
    task automatic send(input logic [W-1:0] c, input logic [W-1:0] s);
        bit done;
        done     = 1'b0;
        c_in     = c;
        s_in     = s;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            #1;
            done = in_ready;
            @(posedge clk);
            #1;
        end
        check("send_accepted", WX'(done), WX'(1));
        in_valid = 1'b0;
        c_in     = rnd();
        s_in     = rnd();
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !out_valid; i++) step();
        check("wait_valid", WX'(out_valid), WX'(1));
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] a, b, c, d;
        ones      = '1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        c_in      = '0;
        s_in      = '0;

        // Reset state
        #12;
        check("rst_sum", WX'(sum), WX'(0));
        check("rst_cout", WX'(cout), WX'(0));
        check("rst_out_valid", WX'(out_valid), WX'(0));
        check("rst_busy", WX'(busy), WX'(0));
        check("rst_in_ready", WX'(in_ready), WX'(1));
        rst = 1'b0;
        step();

        // T1: basic value and exact latency
        out_ready = 1'b1;
        c_in      = '0;
        s_in      = 86'h1234;
        in_valid  = 1'b1;
        #1;
        check("t1_in_ready", WX'(in_ready), WX'(1));
        step();
        in_valid = 1'b0;
        check("t1_busy", WX'(busy), WX'(1));
        for (int i = 1; i <= 3; i++) begin
            step();
            check("t1_latency_early", WX'(out_valid), WX'(0));
        end
        step();
        check("t1_latency", WX'(out_valid), WX'(1));
        check("t1_result", {cout, sum}, WX'(86'h1234));
        step();
        check("t1_to_idle", WX'(out_valid), WX'(0));

        // T2: full ripple across every segment boundary
        send(86'd1, ones);
        wait_valid();
        check("t2_wrap", {cout, sum}, {1'b1, {W{1'b0}}});
        step();

        // T3: carries across seg0->seg1 and seg2->seg3
        send(86'd1 << 21, 86'd1 << 21);
        wait_valid();
        check("t3_seg01", {cout, sum}, 87'd1 << 22);
        step();
        send(86'd1 << 65, 86'd1 << 65);
        wait_valid();
        check("t3_seg23", {cout, sum}, 87'd1 << 66);
        step();

        // T4: back-pressure, then same-cycle hand-over
        out_ready = 1'b0;
        a = rnd();
        b = rnd();
        c = rnd();
        d = rnd();
        send(a, b);
        wait_valid();
        c_in     = c;
        s_in     = d;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t4_in_ready", WX'(in_ready), WX'(0));
            check("t4_stable", {cout, sum}, ref_add(a, b));
            step();
        end
        out_ready = 1'b1;
        #1;
        check("t4_in_ready_pass", WX'(in_ready), WX'(1));
        step();
        in_valid = 1'b0;
        check("t4_same_cycle_accept", WX'(busy), WX'(1));
        wait_valid();
        check("t4_second", {cout, sum}, ref_add(c, d));
        step();

        // T5: reset at seg=2 aborts the operation
        send(ones, 86'h3_ffff_ffff_ffff);
        step();
        step();
        rst = 1'b1;
        #1;
        check("t5_out_valid", WX'(out_valid), WX'(0));
        check("t5_sum", WX'(sum), WX'(0));
        check("t5_busy", WX'(busy), WX'(0));
        check("t5_in_ready", WX'(in_ready), WX'(1));
        step();
        rst = 1'b0;
        #1;
        check("t5_in_ready_after", WX'(in_ready), WX'(1));
        a = rnd();
        b = rnd();
        send(a, b);
        wait_valid();
        check("t5_fresh", {cout, sum}, ref_add(a, b));
        step();

        // T6: random pairs with random stalls on both sides
        rand_ready = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            int gap;
            int mode;
            gap  = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                out_ready = 1'($urandom_range(0, 1));
                step();
            end
            mode = $urandom_range(0, 7);
            case (mode)
                0:       begin a = ones; b = 86'd1; end
                1:       begin a = ones; b = ones;  end
                default: begin a = rnd(); b = rnd(); end
            endcase
            send(a, b);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 100 && (exp_q.size() != 0 || out_valid); i++) step();
        check("t6_drained", WX'(exp_q.size()), WX'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
